// File: rtl/csa_accum_sequencer.sv
// rtl/csa_accum_sequencer.sv - carry-save multi-operand accumulator sequencer (optional abort: CSA_ACCUM_ABORT_EN)
module csa_accum_sequencer #(
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 4,
    localparam int OUT_W = WIDTH + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] op_count,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
`ifdef CSA_ACCUM_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]       state;
    logic [OUT_W-1:0] sum_r;
    logic [OUT_W-1:0] carry_r;
    logic [CNT_W-1:0] remaining;
    logic [OUT_W-1:0] x;
    logic [OUT_W-1:0] maj;
    logic             abort_req;

`ifdef CSA_ACCUM_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);
    assign x        = {{CNT_W{1'b0}}, in_data};
    // Carry leaves the MSB on shift; the total can never reach 2^OUT_W so nothing is lost.
    assign maj      = (sum_r & carry_r) | (sum_r & x) | (carry_r & x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sum_r     <= '0;
            carry_r   <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sum_r   <= '0;
                        carry_r <= '0;
                        if (op_count != '0) begin
                            remaining <= op_count;
                            state     <= ACCUM;
                        end else begin
                            state <= RESOLVE;
                        end
                    end
                end
                ACCUM: begin
                    if (abort_req) begin
                        sum_r     <= '0;
                        carry_r   <= '0;
                        remaining <= '0;
                        state     <= IDLE;
                    end else if (in_valid) begin
                        sum_r     <= sum_r ^ carry_r ^ x;
                        carry_r   <= maj << 1;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    if (abort_req) begin
                        sum_r     <= '0;
                        carry_r   <= '0;
                        remaining <= '0;
                        state     <= IDLE;
                    end else begin
                        out_data  <= sum_r + carry_r;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    // A presented result is never withdrawn, even on abort.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// tb/tb_csa_accum_sequencer.sv - randomized self-checking bench for csa_accum_sequencer
module tb_csa_accum_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int OUT_W = WIDTH + CNT_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] op_count = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_ready = 1'b1;
    logic             busy;
`ifdef CSA_ACCUM_ABORT_EN
    logic             abort = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int job_ops[$];

    csa_accum_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op_count(op_count),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
`ifdef CSA_ACCUM_ABORT_EN
        .abort(abort),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_sum();
        int s = 0;
        foreach (job_ops[i]) s += job_ops[i];
        return s % (1 << OUT_W);
    endfunction

    task automatic start_job(input int n);
        start    = 1'b1;
        op_count = CNT_W'(n);
        tick();
        start    = 1'b0;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic feed(input int n, input int gap_pct, output int rdy_cycles, output int busy_low);
        int idx = 0;
        int cycles = 0;
        bit hs;
        rdy_cycles = 0;
        busy_low = 0;
        while (idx < n && cycles < 400) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = WIDTH'(job_ops[idx]);
            if (in_ready) rdy_cycles++;
            if (!busy) busy_low++;
            hs = in_valid && in_ready;
            tick();
            if (hs) idx++;
            cycles++;
        end
        in_valid = 1'b0;
        check("feed_done", 32'(idx), 32'(n));
    endtask

    task automatic finish_job(input int exp, input int hold);
        check("resolve_valid", 32'(out_valid), 0);
        check("resolve_ready", 32'(in_ready), 0);
        check("resolve_busy", 32'(busy), 1);
        tick();
        check("out_valid", 32'(out_valid), 1);
        check("out_data", 32'(out_data), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            start    = 1'(($urandom_range(1)));
            op_count = CNT_W'($urandom_range(15));
            tick();
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(exp));
            check("hold_busy", 32'(busy), 1);
        end
        start     = (hold > 0);
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("post_hs_valid", 32'(out_valid), 0);
        check("post_hs_busy", 32'(busy), 0);
        tick();
        check("idle_busy", 32'(busy), 0);
    endtask

    task automatic run_job(input int gap_pct, input int hold, output int rdy_cycles, output int busy_low);
        int n = job_ops.size();
        int exp = model_sum();
        out_ready = (hold == 0);
        start_job(n);
        feed(n, gap_pct, rdy_cycles, busy_low);
        finish_job(exp, hold);
    endtask

    initial begin
        int rdy;
        int bl;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        job_ops = '{200, 100, 50};
        run_job(0, 0, rdy, bl);
        check("job3_ready_cycles", 32'(rdy), 3);

        job_ops.delete();
        for (int i = 0; i < 15; i++) job_ops.push_back(255);
        check("job15_model", 32'(model_sum()), 32'h0EF1);
        run_job(40, 0, rdy, bl);
        check("job15_busy_low", 32'(bl), 0);

        job_ops.delete();
        run_job(0, 0, rdy, bl);
        check("job0_ready_cycles", 32'(rdy), 0);

        job_ops = '{7, 9};
        run_job(0, 4, rdy, bl);

        job_ops = '{11, 22, 33, 44, 55};
        out_ready = 1'b1;
        start_job(5);
        feed(2, 0, rdy, bl);
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_data", 32'(out_data), 0);
        check("midrst_ready", 32'(in_ready), 0);
        check("midrst_busy", 32'(busy), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        job_ops = '{1, 2};
        run_job(0, 0, rdy, bl);

`ifdef CSA_ACCUM_ABORT_EN
        job_ops = '{5, 6, 7, 8};
        start_job(4);
        feed(2, 0, rdy, bl);
        abort    = 1'b1;
        in_valid = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_valid", 32'(out_valid), 0);
        end
        job_ops = '{10, 20};
        run_job(0, 0, rdy, bl);
`endif

        for (int j = 0; j < 10; j++) begin
            int n = $urandom_range(15);
            job_ops.delete();
            for (int i = 0; i < n; i++) job_ops.push_back($urandom_range(255));
            run_job(30, $urandom_range(3), rdy, bl);
            check("rand_busy_low", 32'(bl), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
